operand_fetch_stage: RTL
========================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports in_valid input 1 and in_ready output 1: decode-side handshake; transfer when both are 1.
REQ-004 SHALL have ports in_rn, in_rm, in_rd  input  5 each: source and destination register numbers of the instruction being presented.
REQ-005 SHALL have ports in_imm input 64 (extended immediate) and in_ctrl input 16 (ctrl_t, opaque control bundle).
REQ-006 SHALL have ports rd1, rd2  input  64 each: register-file read data for in_rn/in_rm, same cycle.
REQ-007 SHALL have ports wb_we input 1, wb_reg input 5, wb_data input 64: identical copy of the register-file write port.
REQ-008 SHALL have port flush  input  1  discard all held entries.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: execute-side handshake.
REQ-010 SHALL have ports out_a, out_b output 64, out_rd output 5, out_imm output 64, out_ctrl output 16: held entry's payload.

Function
REQ-011 SHALL hold at most two entries: output register (OUT) and skid register (SKID).
REQ-012 SHALL use states EMPTY (none), ONE (OUT valid), FULL (OUT and SKID valid); out_valid = state != EMPTY.
REQ-013 SHALL drive in_ready = (state != FULL) and not flush.
REQ-014 SHALL capture an accepted input into OUT when OUT is empty or draining this cycle, else into SKID; latency accept-to-out_valid exactly 1 cycle.
REQ-015 SHALL, on FULL with out_ready=1, move SKID to OUT next cycle and go to ONE; no simultaneous accept, since in_ready=0.
REQ-016 SHALL sustain one transfer per cycle in state ONE when in_valid and out_ready are both 1.
REQ-017 SHALL hold the OUT payload stable while out_valid=1 and out_ready=0, except for operand refresh (REQ-020).
REQ-018 SHALL treat register 31 as XZR: an operand whose source number is 31 is captured as 0 regardless of rd1/rd2.
REQ-019 SHALL store in_rn/in_rm with each entry for refresh.
REQ-020 SHALL refresh held operands (feature-gated, REQ-026): on wb_we=1, any held entry with source == wb_reg (not 31) loads wb_data into that operand; both operands when rn==rm.
REQ-021 SHALL, on flush=1, go to EMPTY next cycle, drop any same-cycle input and ignore out_ready; flush has priority over all transfers.

Reset
REQ-022 SHALL, with reset=0 at a clock edge, enter EMPTY; out_valid=0.
REQ-023 SHALL reset out_a, out_b, out_imm to 0, out_rd to 0, out_ctrl to 0, SKID payload to 0.
REQ-024 SHALL give reset priority over flush and handshakes; reset mid-transfer discards both entries.
REQ-025 SHALL drive in_ready=0 while reset=0.

Configuration
REQ-026 SHALL, with OPFETCH_BYPASS_EN defined, forward wb_data at capture when wb_we=1 and wb_reg equals in_rn/in_rm (not 31), and perform REQ-020 refresh.
REQ-027 SHALL, without OPFETCH_BYPASS_EN, capture rd1/rd2 raw (XZR rule still applies), perform no refresh, and leave wb_* ports present but unused.

Structure
REQ-028 SHALL take REG_ZR (5'd31), ctrl_t (16-bit) and opnd_entry_t (rn, rm, rd, a, b, imm, ctrl) from shared package cpu_pkg.
REQ-029 SHALL implement per-operand select (XZR / bypass / raw) in one sub-module opfetch_bypass, instantiated twice at capture and once per held operand for refresh.

Verification
REQ-030 Accept rn=3, rd1=0x55, out_ready=1 -> next cycle out_valid=1, out_a=0x55; following cycle out_valid=0 if no new input.
REQ-031 With OPFETCH_BYPASS_EN: in_rn=5, rd1=0x1, wb_we=1, wb_reg=5, wb_data=0xAB -> out_a=0xAB; same with wb_reg=31, in_rn=31 -> out_a=0.
REQ-032 out_ready=0, accept two entries -> state FULL, in_ready=0; out_ready=1 -> entries emerge in order, one per cycle.
REQ-033 Entry held (rm=7, out_ready=0), wb_we=1, wb_reg=7, wb_data=0x99 -> out_b=0x99 next cycle with bypass; unchanged without.
REQ-034 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-035 reset=0 asserted while FULL -> next cycle out_valid=0, all payload outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the operand fetch path: register numbers, control bundle, held entry.
// Feature macro consumed downstream: OPFETCH_BYPASS_EN (write-back forwarding and refresh).
package cpu_pkg;

    localparam logic [4:0] REG_ZR = 5'd31;

    typedef logic [15:0] ctrl_t;

    typedef struct packed {
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        ctrl_t       ctrl;
    } opnd_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } of_state_e;

    function automatic opnd_entry_t entry_zero();
        opnd_entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/opfetch_bypass.sv
// Per-operand select: XZR forces zero, otherwise write-back forwarding (OPFETCH_BYPASS_EN) or raw value.
// Purely combinational; used both at capture and for refreshing held operands.
module opfetch_bypass
    import cpu_pkg::*;
(
    input  logic [4:0]  src_i,
    input  logic [63:0] raw_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_reg_i,
    input  logic [63:0] wb_data_i,
    output logic [63:0] opnd_o
);

`ifdef OPFETCH_BYPASS_EN
    always_comb begin
        opnd_o = raw_i;
        if (src_i == REG_ZR) begin
            opnd_o = '0;
        end else if (wb_we_i && (wb_reg_i == src_i)) begin
            opnd_o = wb_data_i;
        end
    end
`else
    // Write port is kept on the interface so both builds share one netlist boundary.
    logic unused_wb;
    assign unused_wb = ^{wb_we_i, wb_reg_i, wb_data_i};

    always_comb begin
        opnd_o = raw_i;
        if (src_i == REG_ZR) begin
            opnd_o = '0;
        end
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Two-entry (OUT + SKID) operand fetch register between decode and execute, 1-cycle latency.
// in_ready drops when FULL or on flush; optional OPFETCH_BYPASS_EN forwards/refreshes from write-back.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_imm,
    input  logic [15:0] in_ctrl,
    input  logic [63:0] rd1,
    input  logic [63:0] rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [63:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_a,
    output logic [63:0] out_b,
    output logic [4:0]  out_rd,
    output logic [63:0] out_imm,
    output logic [15:0] out_ctrl
);

    of_state_e   state_q, state_d;
    opnd_entry_t out_q, out_d;
    opnd_entry_t skid_q, skid_d;

    logic [63:0] cap_a, cap_b;
    logic [63:0] out_a_ref, out_b_ref, skid_a_ref, skid_b_ref;
    opnd_entry_t cap_e, out_ref, skid_ref;
    logic        accept, drain;

    opfetch_bypass u_cap_a (
        .src_i(in_rn), .raw_i(rd1), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(cap_a)
    );
    opfetch_bypass u_cap_b (
        .src_i(in_rm), .raw_i(rd2), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(cap_b)
    );

    // Held operands pass through the same selector so a matching write-back overwrites them.
    opfetch_bypass u_out_a (
        .src_i(out_q.rn), .raw_i(out_q.a), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(out_a_ref)
    );
    opfetch_bypass u_out_b (
        .src_i(out_q.rm), .raw_i(out_q.b), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(out_b_ref)
    );
    opfetch_bypass u_skid_a (
        .src_i(skid_q.rn), .raw_i(skid_q.a), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(skid_a_ref)
    );
    opfetch_bypass u_skid_b (
        .src_i(skid_q.rm), .raw_i(skid_q.b), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .opnd_o(skid_b_ref)
    );

    assign in_ready  = reset && (state_q != ST_FULL) && !flush;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        cap_e      = '0;
        cap_e.rn   = in_rn;
        cap_e.rm   = in_rm;
        cap_e.rd   = in_rd;
        cap_e.a    = cap_a;
        cap_e.b    = cap_b;
        cap_e.imm  = in_imm;
        cap_e.ctrl = in_ctrl;

        out_ref    = out_q;
        out_ref.a  = out_a_ref;
        out_ref.b  = out_b_ref;
        skid_ref   = skid_q;
        skid_ref.a = skid_a_ref;
        skid_ref.b = skid_b_ref;
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_ref;
        skid_d  = skid_ref;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = cap_e;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_d = cap_e;
                end else if (accept) begin
                    skid_d  = cap_e;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    out_d   = skid_ref;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any transfer; in_ready is already low so nothing is accepted.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            out_q   <= entry_zero();
            skid_q  <= entry_zero();
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_a    = out_q.a;
    assign out_b    = out_q.b;
    assign out_rd   = out_q.rd;
    assign out_imm  = out_q.imm;
    assign out_ctrl = out_q.ctrl;

endmodule
